// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4
// Scanner and decoder for a 4x4 matrix keypad. The block rotates one
// active-low column drive at a time and reads the active-low row lines
// back. A press or a release is accepted only after DEBOUNCE_TICKS
// consecutive matching scan ticks. The block then reports a 4-bit key
// code (row_idx*4 + col_idx) together with a one-clock valid strobe.
//
// Parameters:
//   SCAN_N         prescaler width, one scan tick every 2^SCAN_N clocks
//   DEBOUNCE_TICKS matching ticks needed to accept a press or a release (1..15)
//   REPEAT_TICKS   auto-repeat interval in ticks (1..1023)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   row[3:0]   keypad row lines, active low, asynchronous to clk
//   col[3:0]   column drives, active low, exactly one bit low
//   key_code   last accepted key, row_idx*4 + col_idx
//   key_valid  one-clock strobe when key_code is updated
//   key_down   high while the accepted key is held
//
// Optional feature macro: KEYPAD_REPEAT_EN
//   When it is defined, a held key re-issues key_valid every
//   REPEAT_TICKS ticks. When it is undefined, each accepted press
//   produces exactly one key_valid.
module keypad_scan_4x4 #(
  parameter int unsigned SCAN_N         = 16,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_TICKS   = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_TICKS);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15) begin : g_bad_debounce
    $error("keypad_scan_4x4: DEBOUNCE_TICKS must be 1..15");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > 1023) begin : g_bad_repeat
    $error("keypad_scan_4x4: REPEAT_TICKS must be 1..1023");
  end

  logic [SCAN_N-1:0] prescaler;
  logic [3:0]        row_meta;
  logic [3:0]        rs;
  state_t            state;
  logic [3:0]        deb_cnt;
  logic [1:0]        row_lat;
  logic              tick;
  logic              row_any_low;
  logic              row_held_low;
  logic [1:0]        row_idx;
  logic [1:0]        col_idx;
  logic [3:0]        col_next;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [9:0] REP_LIMIT = 10'(REPEAT_TICKS);
  logic [9:0] rep_cnt;
`endif

  // Free-running prescaler. Its all-ones state marks the scan tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  assign tick = &prescaler;

  // Two-flop synchronizer. It resets to "no row pulled low" so that a key
  // held through reset is seen as a fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= 4'b1111;
      rs       <= 4'b1111;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  // Priority encoders. When several rows are low, row 0 wins.
  always_comb begin
    row_idx = 2'd0;
    if (!rs[0])      row_idx = 2'd0;
    else if (!rs[1]) row_idx = 2'd1;
    else if (!rs[2]) row_idx = 2'd2;
    else if (!rs[3]) row_idx = 2'd3;
  end

  always_comb begin
    col_idx = 2'd0;
    unique case (col)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  assign row_any_low  = (rs != 4'b1111);
  assign row_held_low = ~rs[row_lat];
  assign col_next     = {col[2:0], col[3]};

  // Scan, debounce and hold FSM. Every transition waits for a tick. The
  // column stays frozen while a key is being debounced or held, so the
  // current col_idx always identifies the latched key.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCAN;
      col       <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      deb_cnt   <= 4'd0;
      row_lat   <= 2'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= 10'd0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (row_any_low) begin
              row_lat <= row_idx;
              if (DEB_LIMIT == 4'd1) begin
                key_code  <= {row_idx, col_idx};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                deb_cnt   <= 4'd0;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= 10'd0;
`endif
              end else begin
                deb_cnt <= 4'd1;
                state   <= DEBOUNCE;
              end
            end else begin
              col <= col_next;
            end
          end
          DEBOUNCE: begin
            if (row_held_low) begin
              if (deb_cnt + 4'd1 == DEB_LIMIT) begin
                key_code  <= {row_lat, col_idx};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                deb_cnt   <= 4'd0;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= 10'd0;
`endif
              end else begin
                deb_cnt <= deb_cnt + 4'd1;
              end
            end else begin
              deb_cnt <= 4'd0;
              col     <= col_next;
              state   <= SCAN;
            end
          end
          HELD: begin
            // Only the latched row matters here. Any bounce back to low
            // restarts the release count.
            if (!row_held_low) begin
              if (deb_cnt + 4'd1 == DEB_LIMIT) begin
                key_down <= 1'b0;
                deb_cnt  <= 4'd0;
                col      <= col_next;
                state    <= SCAN;
              end else begin
                deb_cnt <= deb_cnt + 4'd1;
              end
            end else begin
              deb_cnt <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
              if (rep_cnt + 10'd1 == REP_LIMIT) begin
                rep_cnt   <= 10'd0;
                key_valid <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + 10'd1;
              end
`endif
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
- Scanner/decoder for a 4x4 matrix keypad.
- It is the input-side counterpart of the multiplexed seven-segment display driver. That driver rotates active-low enables to write digits out; this block rotates active-low column drives and reads the row lines back in.
- Outputs a debounced 4-bit key code with a one-cycle valid strobe.
- Feeds the stopwatch/UART control logic alongside the display mux, in the same clock domain.

Parameters:
- SCAN_N, 16, prescaler width. One scan tick every 2^SCAN_N clocks (50 MHz / 2^16 ≈ 763 Hz).
- DEBOUNCE_TICKS, 4, consecutive matching ticks needed to accept a press or a release. Range 1..15.
- REPEAT_TICKS, 256, auto-repeat interval in ticks. Used only with KEYPAD_REPEAT_EN. Range 1..1023.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- row  input  4  keypad row lines, active low, externally pulled up, asynchronous
- col  output  4  column drives, active low, exactly one bit low at any time
- key_code  output  4  last accepted key, row_idx*4 + col_idx
- key_valid  output  1  one-clock strobe when key_code is updated
- key_down  output  1  high while the accepted key is held

Behaviour:
- Reset and clocking: one clock, clk; reset_n is asynchronous and active-low.
- Reset values:
  - col=4'b1110, key_code=4'h0, key_valid=0, key_down=0.
  - Prescaler=0, synchronizer flops=4'b1111, state=SCAN, debounce and repeat counters=0.
- Row synchronizer: row passes through a 2-flop synchronizer; all decisions use the synced value rs.
- Prescaler:
  - Free-running SCAN_N-bit up-counter that wraps naturally.
  - tick=1 in the cycle the prescaler equals all-ones.
  - All state transitions happen only on tick cycles, except reset.
- col_idx mapping: col=1110 -> 0, 1101 -> 1, 1011 -> 2, 0111 -> 3.
- row_idx: index of the lowest-numbered zero bit of rs, so row 0 has priority over rows 1, 2 and 3.
- State SCAN:
  - On tick with rs==4'b1111: rotate col left (1110->1101->1011->0111->1110).
  - On tick with any rs bit low: latch row_idx and col_idx, set deb_cnt=1, go to DEBOUNCE. col is held.
  - If DEBOUNCE_TICKS==1, accept the key immediately; same actions as the accept case under DEBOUNCE.
- State DEBOUNCE:
  - On tick, if the latched row is still low: deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_TICKS (accept):
    - key_code <= {row_idx, col_idx}.
    - key_valid=1 for exactly the next clock.
    - key_down <= 1, deb_cnt <= 0, go to HELD.
  - If the latched row is high on a tick: go to SCAN and rotate col. No strobe.
- State HELD:
  - col is held and key_down=1.
  - On tick with the latched row high: deb_cnt++. When it reaches DEBOUNCE_TICKS: key_down <= 0, rotate col, go to SCAN.
  - On tick with the latched row low: deb_cnt=0, so a release bounce restarts the release count.
  - Other rows going low in HELD are ignored, giving no rollover.
- Latency: key_valid rises on the clock after the DEBOUNCE_TICKS-th consecutive matching tick, where the detection tick counts as 1.
- Simultaneous keys:
  - Same column: lowest row wins.
  - Different columns: the first column scanned wins.
- key_code holds its value until the next accept.
- Reset mid-operation: immediate return to the reset values above. A key held through reset deassertion is re-detected as a fresh press.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- When defined:
  - HELD has a 10-bit rep_cnt, cleared on entry to HELD.
  - On each tick where the latched row is low, rep_cnt++.
  - On reaching REPEAT_TICKS: rep_cnt=0 and key_valid pulses for one clock with an unchanged key_code.
  - Release ticks do not advance rep_cnt.
- When undefined: exactly one key_valid per accepted press, and no rep_cnt logic.

Test Plan (SCAN_N=4, so a tick every 16 clocks; DEBOUNCE_TICKS=3):
- Reset with row=1111 -> col=1110, key_code=0, key_valid=0, key_down=0. After release, col steps 1101, 1011, 0111, 1110 at 16-clock intervals.
- Hold row=1101 whenever col=1011 -> detection tick, then two more ticks, then key_valid high for 1 clock. key_code=4'h6, key_down=1, col frozen at 1011.
- Row pulled low for only 1 tick, then 1111 -> no key_valid, key_down stays 0, col advances to the next column on the following tick.
- After the key 6 press, rows high for 3 ticks -> key_down=0 and col goes 1011->0111. Release bounce pattern high, low, high, high, high -> release only after the final 3 highs.
- row=1010 while col=1101 -> key_code=4'h1 (row 0 priority). With KEYPAD_REPEAT_EN and REPEAT_TICKS=4, holding gives a repeat key_valid every 4 ticks with code 1.
- Assert reset_n low mid-HELD for 3 clocks -> outputs at reset values immediately, asynchronously. With the key still held, a fresh key_valid follows 3 ticks after re-detection.
